// File: rtl/abab_seq_pkg.sv
// Shared types and defaults for the abab_seq_gen stimulus generator.
// With ABAB_SEQ_GEN_ERR_INJ_EN defined the state set gains the two extra
// states used to build the illegal b,a,_,a,b frame.
package abab_seq_pkg;

    // Default width of the gap inputs (largest gap is 2^GAP_W-1 cycles)
    localparam int GAP_W_DEF = 4;

`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
    typedef enum logic [2:0] {
        IDLE,
        B_OPEN,
        GAP_BA,
        A_PULSE,
        GAP_AB,
        B_CLOSE,
        A_GAP2,
        A_PULSE2
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        B_OPEN,
        GAP_BA,
        A_PULSE,
        GAP_AB,
        B_CLOSE
    } state_t;
`endif

endpackage

// File: rtl/abab_seq_gen_if.sv
// Handshake bundle between a frame requester and the abab_seq_gen driver.
// master: the side that requests frames (bench / BIST controller).
// slave:  the generator itself.
// inj_err exists only when ABAB_SEQ_GEN_ERR_INJ_EN is defined.
interface abab_seq_gen_if #(
    parameter int GAP_W = 4
);
    logic             start;
    logic [GAP_W-1:0] gap_ba;
    logic [GAP_W-1:0] gap_ab;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
    logic             inj_err;
`endif
    logic             b;
    logic             a;
    logic             busy;
    logic             done;

`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
    modport master (output start, gap_ba, gap_ab, inj_err,
                    input  b, a, busy, done);
    modport slave  (input  start, gap_ba, gap_ab, inj_err,
                    output b, a, busy, done);
`else
    modport master (output start, gap_ba, gap_ab,
                    input  b, a, busy, done);
    modport slave  (input  start, gap_ba, gap_ab,
                    output b, a, busy, done);
`endif

endinterface

// File: rtl/abab_seq_gen_rise_det.sv
// rise_det: registered 0->1 detector. rise is high for the cycle after the
// clock edge at which din is first sampled high following a low sample.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    // Remember the last sample and flag a low-to-high transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end

endmodule

// File: rtl/abab_seq_gen.sv
// abab_seq_gen: on a rising edge of start, drives the frame b -> a -> b with
// programmable idle gaps, then pulses done. Edges arriving while a frame is
// in flight are dropped. All outputs come straight from flops.
// Optional feature macro: ABAB_SEQ_GEN_ERR_INJ_EN (adds inj_err, which turns
// the frame into the illegal b,a,_,a,b sequence).
module abab_seq_gen
    import abab_seq_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    abab_seq_gen_if.slave  bus
);

    state_t           state;
    logic             rise_p1;
    logic [GAP_W-1:0] gba_p0;
    logic [GAP_W-1:0] gab_p0;
    logic [GAP_W-1:0] gba_q;
    logic [GAP_W-1:0] gab_q;
    logic [GAP_W-1:0] cnt;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
    logic             inj_p0;
    logic             inj_q;
`endif

    rise_det u_rise_det (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.start),
        .rise (rise_p1)
    );

    // Capture the frame parameters on every edge so that the value seen on
    // the edge that detected start rising is still available one cycle
    // later, when the FSM acts on the registered rise.
    always_ff @(posedge clk) begin
        gba_p0 <= bus.gap_ba;
        gab_p0 <= bus.gap_ab;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
        inj_p0 <= bus.inj_err;
`endif
    end

    // Frame sequencer with registered a/b/busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gba_q  <= '0;
            gab_q  <= '0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
            inj_q  <= 1'b0;
`endif
        end else begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_p1) begin
                        state  <= B_OPEN;
                        b_q    <= 1'b1;
                        busy_q <= 1'b1;
                        gba_q  <= gba_p0;
                        gab_q  <= gab_p0;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
                        inj_q  <= inj_p0;
`endif
                    end
                end
                B_OPEN: begin
                    if (gba_q != '0) begin
                        state <= GAP_BA;
                        cnt   <= gba_q - GAP_W'(1);
                    end else begin
                        state <= A_PULSE;
                        a_q   <= 1'b1;
                    end
                end
                GAP_BA: begin
                    if (cnt == '0) begin
                        state <= A_PULSE;
                        a_q   <= 1'b1;
                    end else begin
                        cnt <= cnt - GAP_W'(1);
                    end
                end
                A_PULSE: begin
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
                    if (inj_q) begin
                        state <= A_GAP2;
                    end else if (gab_q != '0) begin
                        state <= GAP_AB;
                        cnt   <= gab_q - GAP_W'(1);
                    end else begin
                        state <= B_CLOSE;
                        b_q   <= 1'b1;
                    end
`else
                    if (gab_q != '0) begin
                        state <= GAP_AB;
                        cnt   <= gab_q - GAP_W'(1);
                    end else begin
                        state <= B_CLOSE;
                        b_q   <= 1'b1;
                    end
`endif
                end
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
                A_GAP2: begin
                    state <= A_PULSE2;
                    a_q   <= 1'b1;
                end
                A_PULSE2: begin
                    if (gab_q != '0) begin
                        state <= GAP_AB;
                        cnt   <= gab_q - GAP_W'(1);
                    end else begin
                        state <= B_CLOSE;
                        b_q   <= 1'b1;
                    end
                end
`endif
                GAP_AB: begin
                    if (cnt == '0) begin
                        state <= B_CLOSE;
                        b_q   <= 1'b1;
                    end else begin
                        cnt <= cnt - GAP_W'(1);
                    end
                end
                B_CLOSE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_abab_seq_gen.sv
// Bench for abab_seq_gen: directed scenarios followed by random start/gap
// traffic. Expected waveforms are built from the frame timing rules (launch
// at edge k -> b@k+1, a@k+2+gba, b@k+3+gba+gab, done one cycle later) and
// compared every cycle.
module tb_abab_seq_gen;
    import abab_seq_pkg::*;

    localparam int GAP_W = GAP_W_DEF;
    localparam int N     = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    abab_seq_gen_if #(.GAP_W(GAP_W)) bus ();

    abab_seq_gen #(.GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected output level for each cycle (cycle c = after posedge c)
    bit e_a[N];
    bit e_b[N];
    bit e_busy[N];
    bit e_done[N];
    bit prev_start = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("b",    bus.b,    e_b[cyc]);
        chk("a",    bus.a,    e_a[cyc]);
        chk("busy", bus.busy, e_busy[cyc]);
        chk("done", bus.done, e_done[cyc]);
        chk("a_b_exclusive", bus.a & bus.b, 1'b0);
    endtask

    // Record the frame launched by the rising edge sampled at edge k
    task automatic launch(input int k, input int g1, input int g2, input bit inj);
        int ta;
        int tc;
        ta = k + 2 + g1;
        tc = k + 3 + g1 + g2 + (inj ? 2 : 0);
        e_b[k + 1] = 1'b1;
        e_a[ta]    = 1'b1;
        if (inj) e_a[ta + 2] = 1'b1;
        e_b[tc]        = 1'b1;
        e_done[tc + 1] = 1'b1;
        for (int t = k + 1; t <= tc; t++) e_busy[t] = 1'b1;
    endtask

    // One clock: apply the launch rule at the edge, then check mid-cycle
    task automatic tick();
        bit inj;
        inj = 1'b0;
        @(posedge clk);
        cyc++;
        if (rst) begin
            prev_start = 1'b0;
        end else begin
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
            inj = bus.inj_err;
`endif
            if (bus.start && !prev_start && !e_busy[cyc])
                launch(cyc, int'(bus.gap_ba), int'(bus.gap_ab), inj);
            prev_start = bus.start;
        end
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset mid-cycle: everything from now on is cancelled
    task automatic async_reset();
        rst = 1'b1;
        #1;
        for (int t = cyc; t < N; t++) begin
            e_a[t]    = 1'b0;
            e_b[t]    = 1'b0;
            e_busy[t] = 1'b0;
            e_done[t] = 1'b0;
        end
        prev_start = 1'b0;
        check_all();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.gap_ba = '0;
        bus.gap_ab = '0;
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
        bus.inj_err = 1'b0;
`endif
        // Reset state and quiet idle
        #1;
        check_all();
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Minimum frame; start held high past done must not relaunch
        bus.start = 1'b1;
        tick();
        repeat (6) tick();
        bus.start = 1'b0;
        tick();

        // Gaps 2/3, gap_ba changed to 7 mid-frame
        bus.gap_ba = GAP_W'(2);
        bus.gap_ab = GAP_W'(3);
        bus.start  = 1'b1;
        tick();
        tick();
        bus.gap_ba = GAP_W'(7);
        repeat (10) tick();
        bus.start  = 1'b0;
        bus.gap_ba = '0;
        bus.gap_ab = '0;
        tick();

        // Second edge two cycles into a frame is dropped, start then held high
        bus.gap_ba = GAP_W'(1);
        bus.gap_ab = GAP_W'(1);
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        repeat (8) tick();
        bus.start  = 1'b0;
        bus.gap_ba = '0;
        bus.gap_ab = '0;
        tick();

        // Fresh edge rising in the done cycle launches the next frame
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        repeat (6) tick();
        bus.start = 1'b0;
        tick();

        // Reset inside the gap_ba phase, then a normal frame
        bus.gap_ba = GAP_W'(2);
        bus.gap_ab = GAP_W'(1);
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        async_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        bus.start = 1'b1;
        repeat (8) tick();
        bus.start = 1'b0;
        tick();

`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
        // Injected error frame b,a,_,a,b
        bus.gap_ba  = '0;
        bus.gap_ab  = '0;
        bus.inj_err = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.inj_err = 1'b0;
        bus.start   = 1'b0;
        repeat (8) tick();
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 7) == 0) begin
                bus.gap_ba = GAP_W'($urandom_range(0, (1 << GAP_W) - 1));
                bus.gap_ab = GAP_W'($urandom_range(0, (1 << GAP_W) - 1));
            end else begin
                bus.gap_ba = GAP_W'($urandom_range(0, 3));
                bus.gap_ab = GAP_W'($urandom_range(0, 3));
            end
`ifdef ABAB_SEQ_GEN_ERR_INJ_EN
            bus.inj_err = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        bus.start = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
